// File: rtl/thermocouple_pkg.sv
`default_nettype none
// ============================================================================
// thermocouple_pkg : shared frame layout and FSM encoding for the 32-bit
//                    thermocouple SPI read protocol.  Rev 1.0
// ============================================================================
package thermocouple_pkg;

  localparam int FRAME_BITS    = 32;
  localparam int TC_MSB        = 31;
  localparam int TC_LSB        = 18;
  localparam int FAULT_SUM_BIT = 16;
  localparam int JT_MSB        = 15;
  localparam int JT_LSB        = 4;
  localparam int FAULT_MSB     = 2;
  localparam int TC_W          = 14;
  localparam int JT_W          = 12;
  localparam int FAULT_W       = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [TC_W-1:0]    tc;
    logic [JT_W-1:0]    jt;
    logic [FAULT_W-1:0] fault;
  } meas_t;

  function automatic logic [FRAME_BITS-1:0] build_frame(input meas_t m);
    logic [FRAME_BITS-1:0] f;
    f                   = '0;
    f[TC_MSB:TC_LSB]    = m.tc;
    f[FAULT_SUM_BIT]    = |m.fault;
    f[JT_MSB:JT_LSB]    = m.jt;
    f[FAULT_MSB:0]      = m.fault;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/thermocouple_spi_responder_sync_edge_detect.sv
`default_nettype none
// ============================================================================
// sync_edge_detect : multi-flop synchroniser followed by an edge-detect flop.
//                    Rev 1.0
// ============================================================================
module sync_edge_detect #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule
`default_nettype wire

// File: rtl/thermocouple_spi_responder.sv
`default_nettype none
// ============================================================================
// thermocouple_spi_responder : device side of the 32-bit thermocouple SPI read
//                              (mode 0, MSB first, read-only).  Rev 1.0
// ============================================================================
module thermocouple_spi_responder
  import thermocouple_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TC_W-1:0]   tc_temp_in,
  input  logic [JT_W-1:0]   junction_temp_in,
  input  logic [FAULT_W-1:0] fault_in,
  input  logic              sample_valid,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  output logic              spi_miso,
  output logic              miso_oe,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_abort
);

  localparam int         SETTLE_W   = $clog2(SYNC_STAGES + 2) + 1;
  localparam logic [5:0] RISE_FULL  = 6'(FRAME_BITS);
  localparam logic [4:0] LAST_FALL  = 5'(FRAME_BITS - 2);

  logic sck_level, sck_rise, sck_fall;
  logic cs_level, cs_rise, cs_fall;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst(rst), .async_in(spi_sck),
    .level(sck_level), .rise(sck_rise), .fall(sck_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .async_in(spi_cs_n),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  state_e                state_q, state_d;
  logic [FRAME_BITS-2:0] shift_q, shift_d;
  logic                  miso_q, miso_d;
  logic                  oe_q, oe_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  abort_q, abort_d;
  logic [5:0]            rise_cnt_q, rise_cnt_d;
  logic [4:0]            fall_cnt_q, fall_cnt_d;
  meas_t                 meas_q, meas_d;
  meas_t                 pend_q, pend_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [SETTLE_W-1:0]   settle_q, settle_d;
  logic                  armed_q, armed_d;
  logic [FRAME_BITS-1:0] frame;
  meas_t                 new_sample;

  assign frame      = build_frame(meas_q);
  assign new_sample = meas_t'({tc_temp_in, junction_temp_in, fault_in});

  // A CS fall only counts once CS has been seen high after the synchronisers
  // settle, so a reset released while CS is already low cannot start a frame.
  always_comb begin
    settle_d = settle_q;
    if (settle_q != SETTLE_W'(SYNC_STAGES + 1)) settle_d = settle_q + 1'b1;
    armed_d = armed_q | ((settle_q == SETTLE_W'(SYNC_STAGES + 1)) & cs_level);
  end

  always_comb begin
    meas_d       = meas_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    if (state_q == IDLE) begin
      if (sample_valid)      meas_d = new_sample;
      else if (pend_valid_q) meas_d = pend_q;
      pend_valid_d = 1'b0;
    end else if (sample_valid) begin
      pend_d       = new_sample;
      pend_valid_d = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    rise_cnt_d = rise_cnt_q;
    fall_cnt_d = fall_cnt_q;
    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        oe_d   = 1'b0;
        busy_d = 1'b0;
        // Mode 0 requires SCK idle low when CS falls.
        if (cs_fall && armed_q && !sck_level) begin
          state_d    = LOAD;
          oe_d       = 1'b1;
          busy_d     = 1'b1;
          rise_cnt_d = '0;
          fall_cnt_d = '0;
        end
      end
      LOAD, SHIFT, DONE: begin
        if (cs_rise) begin
          state_d = IDLE;
          miso_d  = 1'b0;
          oe_d    = 1'b0;
          busy_d  = 1'b0;
          if (rise_cnt_q == RISE_FULL) done_d  = 1'b1;
          else                         abort_d = 1'b1;
        end else if (state_q == LOAD) begin
          state_d    = SHIFT;
          shift_d    = frame[FRAME_BITS-2:0];
          miso_d     = frame[FRAME_BITS-1];
          rise_cnt_d = '0;
          fall_cnt_d = '0;
        end else begin
          if (sck_rise && rise_cnt_q != RISE_FULL) rise_cnt_d = rise_cnt_q + 6'd1;
          if (sck_fall) begin
            if (state_q == SHIFT) begin
              miso_d     = shift_q[FRAME_BITS-2];
              shift_d    = {shift_q[FRAME_BITS-3:0], 1'b0};
              fall_cnt_d = fall_cnt_q + 5'd1;
              if (fall_cnt_q == LAST_FALL) state_d = DONE;
            end else begin
              miso_d = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      miso_q       <= 1'b0;
      oe_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      abort_q      <= 1'b0;
      rise_cnt_q   <= '0;
      fall_cnt_q   <= '0;
      meas_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      settle_q     <= '0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      miso_q       <= miso_d;
      oe_q         <= oe_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      abort_q      <= abort_d;
      rise_cnt_q   <= rise_cnt_d;
      fall_cnt_q   <= fall_cnt_d;
      meas_q       <= meas_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      settle_q     <= settle_d;
      armed_q      <= armed_d;
    end
  end

  assign spi_miso    = miso_q;
  assign miso_oe     = oe_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign frame_abort = abort_q;

endmodule
`default_nettype wire
